// File: rtl/metropolis_exp_pkg.sv
// metropolis_exp_pkg: constants, fixed-point types, FSM states and the result
// clamp shared by the Metropolis exponential unit.
package metropolis_exp_pkg;

    localparam int EXP_ONE   = 32768;
    localparam int EXP_TERMS = 14;
    localparam int EXP_X_MIN = -131072;
    localparam int EXP_X_MAX = 131071;

    typedef logic signed [20:0] exp_acc_t;   // Q5.15
    typedef logic signed [17:0] exp_x_t;     // Q3.15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        HOLD = 2'd2
    } exp_state_t;

    // Clamp a Q5.15 accumulator into the unsigned Q1.15 result range [0, 1.0].
    function automatic logic [15:0] exp_clamp(input exp_acc_t a);
        logic [15:0] r;
        if (a < 21'sd0) begin
            r = 16'd0;
        end else if (a > 21'sd32768) begin
            r = 16'd32768;
        end else begin
            r = a[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/metropolis_exp_if.sv
// metropolis_exp_if: command stream from the node controller plus the decision
// outputs returned to the route-update logic.
interface metropolis_exp_if #(
    parameter int DW = 24
);
    logic          exp_init;
    logic          exp_run;
    logic          exp_fin;
    logic [16:0]   exp_recip;
    logic [DW-1:0] delta_dist;
    logic [15:0]   beta;
    logic [14:0]   rand_in;
    logic          accept_valid;
    logic          accept;
    logic [15:0]   exp_result;
    logic          seq_err;

    modport master (
        output exp_init, exp_run, exp_fin, exp_recip, delta_dist, beta, rand_in,
        input  accept_valid, accept, exp_result, seq_err
    );

    modport slave (
        input  exp_init, exp_run, exp_fin, exp_recip, delta_dist, beta, rand_in,
        output accept_valid, accept, exp_result, seq_err
    );
endinterface

// File: rtl/metropolis_exp_horner_step.sv
// exp_horner_step: one Horner step of the Taylor series,
// acc_next = ONE + (((x*acc) >>> 15) * recip) >>> 15, arithmetic truncating shifts.
module exp_horner_step
    import metropolis_exp_pkg::*;
(
    input  exp_x_t      x,
    input  exp_acc_t    acc,
    input  logic [16:0] recip,
    output exp_acc_t    acc_next
);
    logic signed [38:0] xa_s;
    logic signed [38:0] xa_sh_s;
    logic signed [56:0] tr_s;

    // Full-width products; the final sum wraps into the Q5.15 accumulator.
    always_comb begin
        xa_s     = 39'(x) * 39'(acc);
        xa_sh_s  = xa_s >>> 15;
        tr_s     = 57'(xa_sh_s) * 57'($signed({1'b0, recip}));
        acc_next = 21'((tr_s >>> 15) + 57'(EXP_ONE));
    end
endmodule

// File: rtl/metropolis_exp.sv
// metropolis_exp: exp(-beta*delta) by a 14-term Horner series and the Metropolis
// accept/reject decision. Optional feature macro: EXP_ZERO_CLAMP_EN.
module metropolis_exp
    import metropolis_exp_pkg::*;
#(
    parameter int DW = 24
) (
    input logic             clk,
    input logic             reset,
    metropolis_exp_if.slave bus
);
    localparam int PW = DW + 17;
    localparam int NW = PW + 1;

    exp_state_t  state_r, state_s;
    logic [3:0]  step_r, step_s;
    exp_acc_t    acc_r, acc_s, horner_s;
    exp_x_t      x_r, x_s, x_new_s;
    logic        free_r, free_s;
    logic        zero_r, zero_s, zero_new_s;
    logic        accept_valid_r, accept_valid_s;
    logic        accept_r, accept_s;
    logic        seq_err_r, seq_err_s;
    logic [15:0] result_r, result_s, fin_result_s;
    logic signed [PW-1:0] prod_s;
    logic signed [NW-1:0] neg_s;

    exp_horner_step u_step (
        .x        (x_r),
        .acc      (acc_r),
        .recip    (bus.exp_recip),
        .acc_next (horner_s)
    );

    // Saturated exponent argument for a new operation; wide enough that negation cannot overflow.
    always_comb begin
        prod_s = PW'($signed(bus.delta_dist)) * PW'($signed({1'b0, bus.beta}));
        neg_s  = -NW'(prod_s);
        if (neg_s < NW'(EXP_X_MIN)) begin
            x_new_s = exp_x_t'(EXP_X_MIN);
        end else if (neg_s > NW'(EXP_X_MAX)) begin
            x_new_s = exp_x_t'(EXP_X_MAX);
        end else begin
            x_new_s = neg_s[17:0];
        end
`ifdef EXP_ZERO_CLAMP_EN
        zero_new_s = (neg_s < NW'(EXP_X_MIN));
`else
        zero_new_s = 1'b0;
`endif
    end

    // Result presented at exp_fin: improving moves always see full scale.
    always_comb begin
        if (free_r) begin
            fin_result_s = 16'd32768;
        end else if (zero_r) begin
            fin_result_s = 16'd0;
        end else begin
            fin_result_s = exp_clamp(acc_r);
        end
    end

    // Next-state logic: exp_fin is judged against the current state before exp_init restarts.
    always_comb begin
        state_s        = state_r;
        step_s         = step_r;
        acc_s          = acc_r;
        x_s            = x_r;
        free_s         = free_r;
        zero_s         = zero_r;
        accept_valid_s = 1'b0;
        accept_s       = accept_r;
        result_s       = result_r;
        seq_err_s      = seq_err_r;

        if (bus.exp_fin) begin
            if (state_r == HOLD) begin
                result_s       = fin_result_s;
                accept_s       = free_r | (fin_result_s > {1'b0, bus.rand_in});
                accept_valid_s = 1'b1;
            end else begin
                seq_err_s = 1'b1;
            end
            state_s = IDLE;
        end else if (bus.exp_run) begin
            case (state_r)
                ITER: begin
                    acc_s  = horner_s;
                    step_s = step_r + 4'd1;
                    if (step_r == 4'(EXP_TERMS - 1)) begin
                        state_s = HOLD;
                    end else begin
                        state_s = ITER;
                    end
                end
                HOLD:    seq_err_s = 1'b1;
                default: state_s = state_r;
            endcase
        end else begin
            state_s = state_r;
        end

        if (bus.exp_init) begin
            x_s     = x_new_s;
            acc_s   = exp_acc_t'(EXP_ONE);
            step_s  = 4'd0;
            free_s  = ($signed(bus.delta_dist) <= $signed({DW{1'b0}}));
            zero_s  = zero_new_s;
            state_s = ITER;
        end else begin
            free_s = free_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            step_r         <= 4'd0;
            acc_r          <= 21'sd0;
            x_r            <= 18'sd0;
            free_r         <= 1'b0;
            zero_r         <= 1'b0;
            accept_valid_r <= 1'b0;
            accept_r       <= 1'b0;
            result_r       <= 16'd0;
            seq_err_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            step_r         <= step_s;
            acc_r          <= acc_s;
            x_r            <= x_s;
            free_r         <= free_s;
            zero_r         <= zero_s;
            accept_valid_r <= accept_valid_s;
            accept_r       <= accept_s;
            result_r       <= result_s;
            seq_err_r      <= seq_err_s;
        end
    end

    assign bus.accept_valid = accept_valid_r;
    assign bus.accept       = accept_r;
    assign bus.exp_result   = result_r;
    assign bus.seq_err      = seq_err_r;

endmodule

// File: doc/metropolis_exp.md
# metropolis_exp

Consumer of the exponential-unit command stream (`exp_init` / `exp_run` / `exp_fin` / `exp_recip`) issued by the node controller. It evaluates exp(−β·Δ) with a 14-term Horner Taylor series, one reciprocal per cycle. It then makes the Metropolis accept/reject decision for a 2-opt or or-opt move against a uniform random number. The block sits between the distance-delta datapath and the replica route-update logic, one instance per replica node.

## Interface
- `DW`, 24: signed width of the distance delta.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `exp_init` input 1: start pulse; samples `delta_dist` and `beta`.
- `exp_run` input 1: one Horner step per high cycle; `exp_recip` is valid on these cycles.
- `exp_fin` input 1: end pulse; triggers the decision.
- `exp_recip` input 17: unsigned Q2.15, equal to 2^15/n. Delivered in the order n = 14, 13, …, 1.
- `delta_dist` input DW: signed integer distance change (new − old).
- `beta` input 16: unsigned Q1.15 inverse temperature.
- `rand_in` input 15: uniform Q0.15 random number, sampled on `exp_fin`.
- `accept_valid` output 1: one-cycle pulse carrying the decision.
- `accept` output 1: move accepted; valid with `accept_valid`.
- `exp_result` output 16: unsigned Q1.15 result in [0, 32768]; held until the next `exp_fin`.
- `seq_err` output 1: sticky protocol-error flag; cleared only by `reset`.

## Operation
- **States:** IDLE, ITER, HOLD.
- **`exp_init` (any state):**
  - x ← sat(−(Δ·β)), signed Q3.15 (18 bit).
  - acc ← ONE (32768), signed Q5.15 (21 bit).
  - step ← 0; state ← ITER.
  - Δ ≤ 0 sets the `free` flag.
- **ITER, `exp_run`=1:**
  - acc ← ONE + ((((x·acc) >>> 15) · recip) >>> 15).
  - Products use full width; the shifts are arithmetic and truncate.
  - step++. When step reaches 14, go to HOLD.
- **HOLD, `exp_run`=1:** ignored; sets `seq_err`.
- **`exp_fin`:**
  - If state = HOLD: `exp_result` ← clamp(acc, 0, 32768), or 32768 if `free`.
  - `accept` ← `free` OR (`exp_result` > `rand_in`).
  - Next cycle `accept_valid`=1; state ← IDLE.
- **`exp_fin` in IDLE or ITER:** sets `seq_err`, no `accept_valid`, state ← IDLE.
- **`exp_run` in IDLE:** ignored; no error.
- **Simultaneous `exp_init` + `exp_fin`:** `exp_fin` is processed against the old state, then `exp_init` restarts the block.
- **Saturation:** x saturates at X_MIN = −4.0 (−131072). Δ·β overflow is saturated before negation.
- **Reset values:** state IDLE; all outputs 0 (`exp_result` 0, `accept` 0, `accept_valid` 0, `seq_err` 0).
- **Reset mid-ITER:** aborts the calculation; no `accept_valid` follows.

## Timing
- The x computation and acc load are registered on the `exp_init` edge.
- The first Horner step happens on the first `exp_run` cycle after that edge.
- Throughput is one step per cycle. Exactly 14 `exp_run` cycles are required between `exp_init` and `exp_fin`.
- `accept_valid` asserts exactly 1 cycle after `exp_fin`. `accept` and `exp_result` are stable from that cycle onward.
- Back-to-back operations are allowed: `exp_init` may arrive in the same cycle as `accept_valid`.

## Configuration
- **`EXP_ZERO_CLAMP_EN` defined:**
  - When the unsaturated x < X_MIN, set a `zero` flag.
  - On `exp_fin`, `exp_result` = 0 and `accept` = `free` only.
  - Iteration still runs, so the 14-step protocol check still applies.
- **`EXP_ZERO_CLAMP_EN` undefined:** x is saturated to X_MIN and evaluated normally, giving a result ≈ 600.

## Structure
- **Shared package gets:**
  - `EXP_ONE` = 32768.
  - `EXP_TERMS` = 14.
  - `EXP_X_MIN` = −131072.
  - `exp_acc_t` (signed 21-bit) and `exp_x_t` (signed 18-bit).
  - The state enum `exp_state_t`.
- **Sub-module:** `exp_horner_step`, combinational: (x, acc, recip) → next acc, with fixed widths. The FSM, step counter and decision logic stay in `metropolis_exp`.

## Test plan
- Δ=−5, β=32768, 14 runs, `rand_in`=32767 → `accept_valid` 1 cycle after `exp_fin`; `accept`=1, `exp_result`=32768.
- Δ=1, β=32768 → `exp_result` = 12055 ±4.
  - `rand_in`=12000 → `accept`=1.
  - `rand_in`=12100 → `accept`=0.
- Δ=10, β=32768:
  - With `EXP_ZERO_CLAMP_EN`: `exp_result`=0, `accept`=0.
  - Without it: `exp_result` = 600 ±4.
- `exp_fin` after only 10 `exp_run` cycles → no `accept_valid`, `seq_err`=1. A following correct 14-step operation completes normally with `seq_err` still 1.
- `reset` asserted at step 7 → all outputs 0. A later `exp_fin` without `exp_init` → `seq_err`=1, no `accept_valid`.
- Back-to-back runs: `exp_init` in the `accept_valid` cycle with Δ=2, β=16384 → second `exp_result` = 12055 ±4; the first result is unaffected.
